// File: rtl/vga_pkg.sv
// +---------------------------------------------------------------+
// | vga_pkg : shared geometry, colour and mode constants          |
// | Rev 1.0 : initial release                                     |
// +---------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;

  // Colour word layout is {r[29:20], g[19:10], b[9:0]}.
  localparam logic [29:0] WHITE   = 30'h3FFF_FFFF;
  localparam logic [29:0] YELLOW  = 30'h3FFF_FC00;
  localparam logic [29:0] CYAN    = 30'h000F_FFFF;
  localparam logic [29:0] GREEN   = 30'h000F_FC00;
  localparam logic [29:0] MAGENTA = 30'h3FF0_03FF;
  localparam logic [29:0] RED     = 30'h3FF0_0000;
  localparam logic [29:0] BLUE    = 30'h0000_03FF;
  localparam logic [29:0] BLACK   = 30'h0000_0000;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_e;

  function automatic logic [29:0] grey(input logic [9:0] level);
    return {level, level, level};
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_box_mover.sv
// +---------------------------------------------------------------+
// | vga_box_mover : per-frame bounce of the box origin (bx, by)   |
// | Rev 1.0 : initial release                                     |
// +---------------------------------------------------------------+
`default_nettype none

module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int BOX_SIZE = 64,
  parameter int STEP     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_end_i,
  output logic [10:0] bx_o,
  output logic [9:0]  by_o
);

  localparam logic [11:0] XMAX   = 12'(H_ACTIVE - BOX_SIZE);
  localparam logic [11:0] YMAX   = 12'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic        DIR_POS = 1'b0;
  localparam logic        DIR_NEG = 1'b1;

  logic [10:0] bx_q, bx_d;
  logic [9:0]  by_q, by_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;

  // Sums are widened to 12 bits so the limit compare never wraps.
  logic [11:0] w_bx_inc;
  logic [11:0] w_by_inc;
  assign w_bx_inc = {1'b0, bx_q} + STEP12;
  assign w_by_inc = {2'b00, by_q} + STEP12;

  always_comb begin
    bx_d    = bx_q;
    dir_x_d = dir_x_q;
    if (frame_end_i) begin
      if (dir_x_q == DIR_POS) begin
        if (w_bx_inc >= XMAX) begin
          bx_d    = XMAX[10:0];
          dir_x_d = DIR_NEG;
        end else begin
          bx_d = w_bx_inc[10:0];
        end
      end else begin
        if ({1'b0, bx_q} <= STEP12) begin
          bx_d    = '0;
          dir_x_d = DIR_POS;
        end else begin
          bx_d = bx_q - STEP12[10:0];
        end
      end
    end
  end

  always_comb begin
    by_d    = by_q;
    dir_y_d = dir_y_q;
    if (frame_end_i) begin
      if (dir_y_q == DIR_POS) begin
        if (w_by_inc >= YMAX) begin
          by_d    = YMAX[9:0];
          dir_y_d = DIR_NEG;
        end else begin
          by_d = w_by_inc[9:0];
        end
      end else begin
        if ({2'b00, by_q} <= STEP12) begin
          by_d    = '0;
          dir_y_d = DIR_POS;
        end else begin
          by_d = by_q - STEP12[9:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bx_q    <= '0;
      by_q    <= '0;
      dir_x_q <= DIR_POS;
      dir_y_q <= DIR_POS;
    end else begin
      bx_q    <= bx_d;
      by_q    <= by_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  assign bx_o = bx_q;
  assign by_o = by_q;

endmodule

`default_nettype wire

// File: rtl/vga_pattern_src.sv
// +---------------------------------------------------------------+
// | vga_pattern_src : four-pattern pixel source, 1-cycle latency  |
// | Rev 1.0 : initial release                                     |
// +---------------------------------------------------------------+
`default_nettype none

module vga_pattern_src
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int BOX_SIZE  = 64,
  parameter int STEP      = 2,
  parameter int CHECK_BIT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x_pos_i,
  input  logic [9:0]  y_pos_i,
  input  logic        de_i,
  input  logic        frame_end_i,
  input  logic [1:0]  mode_i,
  output logic [29:0] rgb30_o,
  output logic        rgb_de_o
);

  localparam logic [10:0] BAR1 = 11'(1 * H_ACTIVE / 8);
  localparam logic [10:0] BAR2 = 11'(2 * H_ACTIVE / 8);
  localparam logic [10:0] BAR3 = 11'(3 * H_ACTIVE / 8);
  localparam logic [10:0] BAR4 = 11'(4 * H_ACTIVE / 8);
  localparam logic [10:0] BAR5 = 11'(5 * H_ACTIVE / 8);
  localparam logic [10:0] BAR6 = 11'(6 * H_ACTIVE / 8);
  localparam logic [10:0] BAR7 = 11'(7 * H_ACTIVE / 8);
  localparam logic [11:0] BOX12 = 12'(BOX_SIZE);

  mode_e       mode_q, mode_d;
  logic [29:0] rgb_q, rgb_d;
  logic        rgb_de_q, rgb_de_d;
  logic [10:0] w_bx;
  logic [9:0]  w_by;

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP)
  ) u_box_mover (
    .clk         (clk),
    .rst         (rst),
    .frame_end_i (frame_end_i),
    .bx_o        (w_bx),
    .by_o        (w_by)
  );

  // Mode only changes at the frame boundary to avoid mid-frame tearing.
  assign mode_d = frame_end_i ? mode_e'(mode_i) : mode_q;

  logic [29:0] w_bars;
  always_comb begin
    if      (x_pos_i < BAR1) w_bars = WHITE;
    else if (x_pos_i < BAR2) w_bars = YELLOW;
    else if (x_pos_i < BAR3) w_bars = CYAN;
    else if (x_pos_i < BAR4) w_bars = GREEN;
    else if (x_pos_i < BAR5) w_bars = MAGENTA;
    else if (x_pos_i < BAR6) w_bars = RED;
    else if (x_pos_i < BAR7) w_bars = BLUE;
    else                     w_bars = BLACK;
  end

  logic [29:0] w_check;
  assign w_check = (x_pos_i[CHECK_BIT] ^ y_pos_i[CHECK_BIT]) ? WHITE : BLACK;

  logic [11:0] w_x_ext, w_y_ext, w_bx_ext, w_by_ext;
  logic        w_in_box;
  assign w_x_ext  = {1'b0, x_pos_i};
  assign w_y_ext  = {2'b00, y_pos_i};
  assign w_bx_ext = {1'b0, w_bx};
  assign w_by_ext = {2'b00, w_by};
  assign w_in_box = (w_x_ext >= w_bx_ext) && (w_x_ext < w_bx_ext + BOX12) &&
                    (w_y_ext >= w_by_ext) && (w_y_ext < w_by_ext + BOX12);

  logic [29:0] w_colour;
  always_comb begin
    w_colour = BLACK;
    case (mode_q)
      MODE_BARS:  w_colour = w_bars;
      MODE_CHECK: w_colour = w_check;
      MODE_BOX:   w_colour = w_in_box ? WHITE : BLUE;
      MODE_RAMP:  w_colour = grey(x_pos_i[9:0]);
      default:    w_colour = BLACK;
    endcase
  end

  assign rgb_d    = de_i ? w_colour : BLACK;
  assign rgb_de_d = de_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_BARS;
      rgb_q    <= '0;
      rgb_de_q <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      rgb_q    <= rgb_d;
      rgb_de_q <= rgb_de_d;
    end
  end

  assign rgb30_o  = rgb_q;
  assign rgb_de_o = rgb_de_q;

endmodule

`default_nettype wire
